bp_me_stream_mem_responder: RTL



---
 rtl/bp_me_stream_mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bp_me_stream_mem_responder.sv
// Memory-side BedRock stream endpoint: serves mem_cmd reads/writes from an internal RAM and returns mem_resp.
// Optional BP_ME_STREAM_MEM_RANGE_CHECK_EN flags and blocks accesses above the RAM's address span.
module bp_me_stream_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int data_width_p    = 64,
    parameter int els_p           = 1024,
    parameter int payload_width_p = 16,
    localparam int hdr_width_lp   = payload_width_p + 3 + paddr_width_p + 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [hdr_width_lp-1:0] mem_cmd_header_i,
    input  logic                    mem_cmd_header_v_i,
    output logic                    mem_cmd_header_ready_and_o,
    input  logic                    mem_cmd_has_data_i,
    input  logic [data_width_p-1:0] mem_cmd_data_i,
    input  logic                    mem_cmd_data_v_i,
    output logic                    mem_cmd_data_ready_and_o,
    input  logic                    mem_cmd_last_i,
    output logic [hdr_width_lp-1:0] mem_resp_header_o,
    output logic                    mem_resp_header_v_o,
    input  logic                    mem_resp_header_ready_and_i,
    output logic                    mem_resp_has_data_o,
    output logic [data_width_p-1:0] mem_resp_data_o,
    output logic                    mem_resp_data_v_o,
    input  logic                    mem_resp_data_ready_and_i,
    output logic                    mem_resp_last_o,
    output logic                    error_o
);
    localparam int lg_bytes_lp = $clog2(data_width_p / 8);
    localparam int idx_w_lp    = $clog2(els_p);
    localparam int idx_hi_lp   = idx_w_lp + lg_bytes_lp;
    localparam int cnt_w_lp    = 5;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [hdr_width_lp-1:0] hdr_q, hdr_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic                    hdr_sent_q, hdr_sent_d;
    logic                    data_sent_q, data_sent_d;
    logic [data_width_p-1:0] rd_data_q;
    logic [data_width_p-1:0] mem [els_p];

    logic [3:0]               msg_type;
    logic [paddr_width_p-1:0] addr;
    logic [2:0]               size;
    logic [cnt_w_lp-1:0]      last_beat;
    logic [idx_w_lp-1:0]      base, mask, ram_idx;
    logic                     is_ram_wr, wr_en, oor, hdr_fire, data_fire;
    logic                     unused_bits;

    assign msg_type  = hdr_q[3:0];
    assign addr      = hdr_q[4 +: paddr_width_p];
    assign size      = hdr_q[4 + paddr_width_p +: 3];
    assign is_ram_wr = (msg_type == 4'd1) || (msg_type == 4'd3);

    always_comb begin
        last_beat = '0;
        if (int'(size) > lg_bytes_lp)
            last_beat = (cnt_w_lp'(1) << (int'(size) - lg_bytes_lp)) - cnt_w_lp'(1);
    end

    // Beats wrap inside the size-aligned block so the addressed beat always comes first.
    assign base    = addr[idx_hi_lp-1:lg_bytes_lp];
    assign mask    = idx_w_lp'(last_beat);
    assign ram_idx = (base & ~mask) | ((base + idx_w_lp'(cnt_q)) & mask);

`ifdef BP_ME_STREAM_MEM_RANGE_CHECK_EN
    logic err_q;
    assign oor = |addr[paddr_width_p-1:idx_hi_lp];
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) err_q <= 1'b0;
        else if (state_q != IDLE && oor) err_q <= 1'b1;
    end
    assign error_o = err_q;
`else
    assign oor     = 1'b0;
    assign error_o = 1'b0;
`endif

    assign unused_bits = ^{mem_cmd_has_data_i, mem_cmd_last_i, addr};

    assign mem_cmd_header_ready_and_o = (state_q == IDLE) && reset_n_i;
    assign mem_cmd_data_ready_and_o   = (state_q == WR) && reset_n_i;
    assign mem_resp_header_o   = hdr_q;
    assign mem_resp_header_v_o = (state_q == WR_RESP) || (state_q == RD_DATA && !hdr_sent_q);
    assign mem_resp_has_data_o = (state_q == RD_DATA);
    assign mem_resp_data_v_o   = (state_q == RD_DATA) && !data_sent_q;
    assign mem_resp_data_o     = rd_data_q;
    assign mem_resp_last_o     = (state_q == WR_RESP) || (state_q == RD_DATA && cnt_q == last_beat);

    assign hdr_fire  = mem_resp_header_v_o && mem_resp_header_ready_and_i;
    assign data_fire = mem_resp_data_v_o && mem_resp_data_ready_and_i;
    assign wr_en     = mem_cmd_data_ready_and_o && mem_cmd_data_v_i && is_ram_wr && !oor;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        hdr_sent_d  = hdr_sent_q;
        data_sent_d = data_sent_q;
        case (state_q)
            IDLE: if (mem_cmd_header_v_i) begin
                hdr_d   = mem_cmd_header_i;
                cnt_d   = '0;
                state_d = (mem_cmd_header_i[3:0] == 4'd0 || mem_cmd_header_i[3:0] == 4'd2) ? RD_REQ : WR;
            end
            WR: if (mem_cmd_data_v_i) begin
                if (cnt_q == last_beat) state_d = WR_RESP;
                else cnt_d = cnt_q + cnt_w_lp'(1);
            end
            WR_RESP: if (mem_resp_header_ready_and_i) state_d = IDLE;
            RD_REQ: begin
                // Only beat 0 carries the response header.
                hdr_sent_d  = (cnt_q != '0);
                data_sent_d = 1'b0;
                state_d     = RD_DATA;
            end
            RD_DATA: begin
                hdr_sent_d  = hdr_sent_q || hdr_fire;
                data_sent_d = data_sent_q || data_fire;
                if (hdr_sent_d && data_sent_d) begin
                    if (cnt_q == last_beat) state_d = IDLE;
                    else begin
                        cnt_d   = cnt_q + cnt_w_lp'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            cnt_q       <= '0;
            hdr_sent_q  <= 1'b0;
            data_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
            hdr_sent_q  <= hdr_sent_d;
            data_sent_q <= data_sent_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[ram_idx] <= mem_cmd_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) rd_data_q <= '0;
        else if (state_q == RD_REQ) rd_data_q <= oor ? '1 : mem[ram_idx];
    end
endmodule
